// File: rtl/debounce_buttons.sv
// Multi-button debouncer sampled by the divided debounce clock; registered level plus press/release pulses.
// Build option: define AUTO_REPEAT_EN for auto-repeat press pulses while a button stays held.
module debounce_buttons #(
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned ACTIVE_LOW_BTN = 1,
    parameter int unsigned REPEAT_DELAY   = 25,
    parameter int unsigned REPEAT_RATE    = 5
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sample_clk,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int unsigned CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
    localparam logic [N_BTN-1:0] REL_LEVEL = (ACTIVE_LOW_BTN != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

    if (STABLE_SAMPLES < 2) begin : g_cfg_check
        $error("STABLE_SAMPLES must be >= 2");
    end

    logic [N_BTN-1:0] btn_s1, btn_s2;
    logic             sc_s1, sc_s2, sc_hist;
    logic             tick;
    logic [N_BTN-1:0] sample;

    logic [N_BTN-1:0][1:0]    state_q, state_nxt;
    logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_nxt;
    logic [N_BTN-1:0]         level_nxt, press_nxt, release_nxt;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

    if (REPEAT_RATE == 0 || REPEAT_RATE > REPEAT_DELAY) begin : g_rpt_check
        $error("REPEAT_RATE must be in 1..REPEAT_DELAY");
    end

    logic [N_BTN-1:0][RW-1:0] rpt_q, rpt_nxt;
`else
    // Repeat timing has no effect without auto-repeat; the empty block only references it.
    if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_rpt_unused
    end
`endif

    // Synchronizers; buttons settle to the released level in reset.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            btn_s1  <= REL_LEVEL;
            btn_s2  <= REL_LEVEL;
            sc_s1   <= 1'b0;
            sc_s2   <= 1'b0;
            sc_hist <= 1'b0;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            sc_s1   <= sample_clk;
            sc_s2   <= sc_s1;
            sc_hist <= sc_s2;
        end
    end

    assign tick   = sc_s2 & ~sc_hist;
    assign sample = btn_s2 ^ REL_LEVEL;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= {N_BTN{ST_RELEASED}};
            cnt_q       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
`ifdef AUTO_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
`ifdef AUTO_REPEAT_EN
            rpt_q       <= rpt_nxt;
`endif
        end
    end

    // Per-button qualification FSM; advances only on a sample tick.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        level_nxt   = '0;
        press_nxt   = '0;
        release_nxt = '0;
`ifdef AUTO_REPEAT_EN
        rpt_nxt     = rpt_q;
`endif
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (tick) begin
                case (state_q[i])
                    ST_RELEASED: begin
                        if (sample[i]) begin
                            state_nxt[i] = ST_PRESS_PEND;
                            cnt_nxt[i]   = CW'(1);
                        end
                    end
                    ST_PRESS_PEND: begin
                        if (!sample[i]) begin
                            state_nxt[i] = ST_RELEASED;
                            cnt_nxt[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_nxt[i] = ST_PRESSED;
                            cnt_nxt[i]   = '0;
                            press_nxt[i] = 1'b1;
`ifdef AUTO_REPEAT_EN
                            rpt_nxt[i]   = '0;
`endif
                        end else begin
                            cnt_nxt[i] = CW'(cnt_q[i] + CW'(1));
                        end
                    end
                    ST_PRESSED: begin
                        if (!sample[i]) begin
                            state_nxt[i] = ST_RELEASE_PEND;
                            cnt_nxt[i]   = CW'(1);
                        end else begin
`ifdef AUTO_REPEAT_EN
                            if (rpt_q[i] == RPT_LAST) begin
                                press_nxt[i] = 1'b1;
                                rpt_nxt[i]   = RPT_RELOAD;
                            end else begin
                                rpt_nxt[i] = RW'(rpt_q[i] + RW'(1));
                            end
`endif
                        end
                    end
                    default: begin
                        if (sample[i]) begin
                            state_nxt[i] = ST_PRESSED;
                            cnt_nxt[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_nxt[i]   = ST_RELEASED;
                            cnt_nxt[i]     = '0;
                            release_nxt[i] = 1'b1;
                        end else begin
                            cnt_nxt[i] = CW'(cnt_q[i] + CW'(1));
                        end
                    end
                endcase
            end
            level_nxt[i] = (state_nxt[i] == ST_PRESSED) || (state_nxt[i] == ST_RELEASE_PEND);
        end
    end

endmodule

// File: tb/tb_debounce_buttons.sv
// Scoreboard bench for debounce_buttons: run-length reference model, directed scenarios, then random bouncing.
module tb_debounce_buttons;

    localparam int RD = 25;
    localparam int RR = 5;
    localparam int S  = 4;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       sample_clk = 1'b0;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] btn_level, btn_press, btn_release;

    debounce_buttons dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sample_clk  (sample_clk),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lvl;
    } exp_t;
    exp_t exp_q[$];

    // Reference: level flips after S consecutive tick samples that disagree with it.
    logic [3:0] m_lvl = 4'b0000;
    int         run[4];
    int         hold[4];

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", nm, cyc, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic model_reset();
        m_lvl = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            run[b]  = 0;
            hold[b] = 0;
        end
    endtask

    // Reset only while sample_clk is low so no tick is pending or created.
    task automatic do_reset(input int n);
        exp_t e;
        sample_clk = 1'b0;
        reset      = 1'b0;
        mon_en     = 1'b1;
        for (int k = 1; k <= n; k++) begin
            e.cyc = cyc + k; e.press = '0; e.rel = '0; e.lvl = '0;
            exp_q.push_back(e);
        end
        model_reset();
        step(n);
        reset = 1'b1;
    endtask

    // One sample_clk period: raw set during the low half, rising edge, high half.
    task automatic do_tick(input logic [3:0] raw);
        exp_t       e;
        logic [3:0] smp;
        sample_clk = 1'b0;
        btn_raw    = raw;
        step(4);
        sample_clk = 1'b1;
        smp     = ~raw;
        e.cyc   = cyc + 3;
        e.press = '0;
        e.rel   = '0;
        for (int b = 0; b < 4; b++) begin
            if (m_lvl[b] && run[b] == 0 && smp[b]) begin
                hold[b]++;
                if (hold[b] == RD) begin
                    hold[b] = RD - RR;
`ifdef AUTO_REPEAT_EN
                    e.press[b] = 1'b1;
`endif
                end
            end
            run[b] = (smp[b] != m_lvl[b]) ? run[b] + 1 : 0;
            if (run[b] == S) begin
                run[b]   = 0;
                m_lvl[b] = ~m_lvl[b];
                if (m_lvl[b]) begin
                    e.press[b] = 1'b1;
                    hold[b]    = 0;
                end else begin
                    e.rel[b] = 1'b1;
                end
            end
        end
        e.lvl = m_lvl;
        exp_q.push_back(e);
        step(4);
    endtask

    // Monitor: pops expectations at their cycle; any other pulse is unexpected.
    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc != cyc) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL late_check at cycle %0d: expected event cycle %0d", cyc, e.cyc);
                end
                check("btn_press", btn_press, e.press);
                check("btn_release", btn_release, e.rel);
                check("btn_level", btn_level, e.lvl);
            end else if ((btn_press | btn_release) !== 4'b0000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_pulse at cycle %0d: press %b release %b, expected 0000",
                         cyc, btn_press, btn_release);
            end
            check("press_release_overlap", btn_press & btn_release, 4'b0000);
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    logic [3:0] pat3[7];
    logic [3:0] pat4[7];
    logic [3:0] raw_r;

    initial begin : stim
        pat3 = '{4'hE, 4'hE, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE};
        pat4 = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF};
        model_reset();

        // Reset with buttons released, then idle with no ticks
        btn_raw = 4'hF;
        do_reset(5);
        step(16);
        check("idle_level", btn_level, 4'b0000);

        // Clean press of button 0
        repeat (4) do_tick(4'hE);
        check("press_level", btn_level, 4'b0001);

        // Release, then bouncy press
        repeat (4) do_tick(4'hF);
        for (int i = 0; i < 7; i++) do_tick(pat3[i]);
        check("bounce_press_level", btn_level, 4'b0001);

        // Bouncy release
        for (int i = 0; i < 7; i++) do_tick(pat4[i]);
        check("bounce_release_level", btn_level, 4'b0000);

        // Reset interrupts a pending press
        repeat (3) do_tick(4'hE);
        do_reset(1);
        check("reset_mid_level", btn_level, 4'b0000);
        repeat (4) do_tick(4'hE);
        check("press_after_reset_level", btn_level, 4'b0001);

        // Release, then buttons 0 and 2 together, held 40 ticks
        repeat (4) do_tick(4'hF);
        repeat (40) do_tick(4'b1010);
        check("held_level", btn_level, 4'b0101);
        repeat (4) do_tick(4'hF);

        // Random bouncing with occasional resets
        raw_r = 4'hF;
        for (int t = 0; t < 400; t++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) raw_r[b] = ~raw_r[b];
            if ($urandom_range(59) == 0) do_reset(int'($urandom_range(3, 1)));
            do_tick(raw_r);
        end

        step(8);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
